// File: rtl/line_split_sequencer.sv
// Splits one CPU access into one or two line-aligned cache sub-requests and merges read data back.
// Latency: 1 cycle capture->mem_valid, 1 cycle last mem_rvalid->resp_valid; mem_*/resp_* held under backpressure.
module line_split_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int MAX_BYTES  = 8,
    parameter int ID_W       = 7,
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int LG_MAX    = $clog2(MAX_BYTES),
    localparam int SZ_W      = ($clog2(LG_MAX + 1) < 1) ? 1 : $clog2(LG_MAX + 1),
    localparam int LINE_W    = ADDR_W - OFF_W,
    localparam int CW        = OFF_W + 1,
    localparam int LB        = LINE_BYTES * 8,
    localparam int MB        = MAX_BYTES * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SZ_W-1:0]   req_size,
    input  logic              req_wr,
    input  logic [MB-1:0]     req_wdata,
    input  logic [ID_W-1:0]   req_id,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [LINE_W-1:0] mem_line,
    output logic              mem_wr,
    output logic [LB-1:0]     mem_wdata,
    output logic [LINE_BYTES-1:0] mem_mask,
    output logic              mem_last,
    input  logic              mem_rvalid,
    input  logic [LB-1:0]     mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [MB-1:0]     resp_rdata,
    output logic [ID_W-1:0]   resp_id,
    output logic              resp_split
);

    typedef enum logic [2:0] {IDLE, SEND0, WAIT0, SEND1, WAIT1, RESP} state_t;

    state_t r_state, w_state_nxt;

    logic                  r_cross, r_wr, r_last;
    logic [OFF_W-1:0]      r_off;
    logic [CW-1:0]         r_b0, r_n;
    logic [LINE_W-1:0]     r_line;
    logic [LB-1:0]         r_wdata, r_wdata1;
    logic [LINE_BYTES-1:0] r_mask, r_mask1;
    logic [ID_W-1:0]       r_id;
    logic [MB-1:0]         r_rdata;

    logic [SZ_W-1:0]       w_sz;
    logic [OFF_W-1:0]      w_off;
    logic [CW-1:0]         w_n, w_end, w_b0, w_b1;
    logic                  w_cross;
    logic [LINE_BYTES-1:0] w_mask0, w_mask1;
    logic [LB-1:0]         w_wdata0, w_wdata1;
    logic [MB-1:0]         w_rsh0, w_rsh1, w_merge0, w_merge1;

    // Split geometry of the incoming request; only consumed on capture.
    always_comb begin
        w_sz     = (req_size > SZ_W'(LG_MAX)) ? SZ_W'(LG_MAX) : req_size;
        w_off    = req_addr[OFF_W-1:0];
        w_n      = CW'(1) << w_sz;
        w_end    = {1'b0, w_off} + w_n;
        w_cross  = w_end > CW'(LINE_BYTES);
        w_b0     = w_cross ? (CW'(LINE_BYTES) - {1'b0, w_off}) : w_n;
        w_b1     = w_n - w_b0;
        w_wdata0 = LB'(req_wdata) << {w_off, 3'b000};
        w_wdata1 = LB'(req_wdata >> {w_b0, 3'b000});
        w_mask0  = '0;
        w_mask1  = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            w_mask0[i] = (CW'(i) >= {1'b0, w_off}) && (CW'(i) < w_end);
            w_mask1[i] = CW'(i) < w_b1;
        end
    end

    // Second-line bytes land directly above the b0 bytes taken from the first line.
    always_comb begin
        w_rsh0   = MB'(mem_rdata >> {r_off, 3'b000});
        w_rsh1   = MB'(mem_rdata) << {r_b0, 3'b000};
        w_merge0 = '0;
        w_merge1 = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            w_merge0[8*k +: 8] = (CW'(k) < r_b0) ? w_rsh0[8*k +: 8] : 8'h00;
            w_merge1[8*k +: 8] = ((CW'(k) >= r_b0) && (CW'(k) < r_n)) ? w_rsh1[8*k +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (req_valid)  w_state_nxt = SEND0;
            SEND0: if (mem_ready)  w_state_nxt = WAIT0;
            WAIT0: if (mem_rvalid) w_state_nxt = r_cross ? SEND1 : RESP;
            SEND1: if (mem_ready)  w_state_nxt = WAIT1;
            WAIT1: if (mem_rvalid) w_state_nxt = RESP;
            RESP:  if (resp_ready) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cross  <= 1'b0;
            r_wr     <= 1'b0;
            r_last   <= 1'b0;
            r_off    <= '0;
            r_b0     <= '0;
            r_n      <= '0;
            r_line   <= '0;
            r_wdata  <= '0;
            r_wdata1 <= '0;
            r_mask   <= '0;
            r_mask1  <= '0;
            r_id     <= '0;
            r_rdata  <= '0;
        end else if (r_state == IDLE) begin
            if (req_valid) begin
                r_cross  <= w_cross;
                r_wr     <= req_wr;
                r_last   <= !w_cross;
                r_off    <= w_off;
                r_b0     <= w_b0;
                r_n      <= w_n;
                r_line   <= req_addr[ADDR_W-1:OFF_W];
                r_wdata  <= w_wdata0;
                r_wdata1 <= w_wdata1;
                r_mask   <= w_mask0;
                r_mask1  <= w_mask1;
                r_id     <= req_id;
                r_rdata  <= '0;
            end
        end else if (r_state == WAIT0) begin
            if (mem_rvalid) begin
                if (!r_wr) r_rdata <= w_merge0;
                if (r_cross) begin
                    r_line  <= r_line + LINE_W'(1);
                    r_mask  <= r_mask1;
                    r_wdata <= r_wdata1;
                    r_last  <= 1'b1;
                end
            end
        end else if (r_state == WAIT1) begin
            if (mem_rvalid && !r_wr) r_rdata <= r_rdata | w_merge1;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign mem_valid  = (r_state == SEND0) || (r_state == SEND1);
    assign mem_line   = r_line;
    assign mem_wr     = r_wr;
    assign mem_wdata  = r_wdata;
    assign mem_mask   = r_mask;
    assign mem_last   = r_last;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_id    = r_id;
    assign resp_split = r_cross;

endmodule

// File: doc/line_split_sequencer.md
Name: line_split_sequencer

Overview:
- Parametrised, sequential successor to the memory-stage input aligner.
- Accepts one CPU-side access of 1..MAX_BYTES bytes at any byte address.
- Splits the access into one or two line-aligned cache sub-requests, issued one after the other over a valid/ready handshake, each with a byte mask and line-positioned write data.
- For reads, merges the returned line data back into a right-justified result. Sits between the M-stage request path and the cache tag/data arrays.

Parameters:
ADDR_W, 32, byte-address width
LINE_BYTES, 16, cache line size in bytes; power of two, >= MAX_BYTES
MAX_BYTES, 8, largest access in bytes; power of two
ID_W, 7, request tag width (matches PTC id)
(derived) OFF_W = log2(LINE_BYTES); SZ_W = log2(log2(MAX_BYTES)+1), min 1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_addr  in  ADDR_W  byte address
req_size  in  SZ_W  log2 of byte count (0=1B .. log2(MAX_BYTES)); larger values clamp to MAX_BYTES
req_wr  in  1  1=write, 0=read
req_wdata  in  MAX_BYTES*8  write data, byte 0 at LSB
req_id  in  ID_W  tag returned with response
mem_valid  out  1  sub-request valid
mem_ready  in  1  cache accepts sub-request
mem_line  out  ADDR_W-OFF_W  line address
mem_wr  out  1  write sub-request
mem_wdata  out  LINE_BYTES*8  write data, positioned in line
mem_mask  out  LINE_BYTES  byte enables
mem_last  out  1  final sub-request of this access
mem_rvalid  in  1  completion/ack for the accepted sub-request (reads carry data)
mem_rdata  in  LINE_BYTES*8  returned line
resp_valid  out  1  access complete
resp_ready  in  1  consumer takes response
resp_rdata  out  MAX_BYTES*8  merged read data, right-justified, upper unused bytes zero; zero for writes
resp_id  out  ID_W  tag of completed access
resp_split  out  1  access used two sub-requests

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1. mem_valid, mem_wr, mem_last, resp_valid, resp_split=0. mem_line, mem_wdata, mem_mask, resp_rdata, resp_id=0. Any in-flight access is dropped; late mem_rvalid after reset is ignored in IDLE.
- Capture on req_valid&req_ready. The block holds a single outstanding access.
- Capture computes: off=addr[OFF_W-1:0]; n=1<<size_clamped; cross=(off+n>LINE_BYTES); b0=cross?LINE_BYTES-off:n; b1=n-b0.
- Sub-request 0: line=addr[ADDR_W-1:OFF_W]; mask=((1<<b0)-1)<<off; wdata=req_wdata<<(8*off), truncated to the line.
- Sub-request 1 (cross only): line=line0+1, modulo 2^(ADDR_W-OFF_W), so the top line wraps to 0; mask=(1<<b1)-1; wdata=req_wdata>>(8*b0).
- FSM states IDLE, SEND0, WAIT0, SEND1, WAIT1, RESP.
  - IDLE -> SEND0 on capture.
  - SEND0: mem_valid=1, mem_last=!cross. Goes to WAIT0 on mem_ready.
  - WAIT0: on mem_rvalid, latch read bytes, then go to SEND1 if cross, else RESP.
  - SEND1: mem_valid=1, mem_last=1. Goes to WAIT1 on mem_ready.
  - WAIT1: on mem_rvalid, go to RESP.
  - RESP: resp_valid=1. Goes to IDLE on resp_ready.
- mem_* outputs are registered and held stable while mem_valid=1 and mem_ready=0. resp_* are held stable while resp_valid=1 and resp_ready=0.
- Read merge: result byte k (k<b0) = rdata0 byte off+k. Result byte b0+j (j<b1) = rdata1 byte j. Bytes >= n are 0.
- Latency with no stalls: capture to mem_valid 1 cycle; last mem_rvalid to resp_valid 1 cycle. Unsplit access: 3 cycles min plus memory latency; split access adds 2 cycles.
- mem_rvalid outside WAIT0/WAIT1 is ignored. req_valid while not IDLE is not accepted.
- A new request is accepted no earlier than the cycle after the RESP handshake; there is no IDLE bypass.
- Writes follow the same FSM; mem_rvalid is the write ack, and resp_rdata=0.

Test Plan (LINE_BYTES=16, MAX_BYTES=8, ADDR_W=32):
- Aligned read, addr 0x100, size 2 -> one sub-request: line 0x10, mask 0x000F, mem_last=1. rdata bytes0-3 = 11 22 33 44 -> resp_rdata=0x44332211, resp_split=0.
- Crossing read, addr 0x10E, size 2 -> line 0x10 mask 0xC000 (last=0), then line 0x11 mask 0x0003 (last=1). rdata0 bytes14,15=AA,BB and rdata1 bytes0,1=CC,DD -> resp_rdata=0xDDCCBBAA, split=1.
- Crossing write, addr 0x10B, size 3, wdata 0x8877665544332211 -> req0 mask 0xF800 with bytes11..15=11,22,33,44,55; req1 mask 0x0007 with bytes0..2=66,77,88; resp_rdata=0.
- Backpressure: hold mem_ready=0 for 5 cycles in SEND1, then resp_ready=0 for 3 cycles -> mem_* and resp_* constant throughout, req_ready=0.
- Wrap: read addr 0xFFFFFFFC, size 3 -> line 0xFFFFFFF mask 0xF000, then line 0x0000000 mask 0x000F.
- Assert rst asynchronously in WAIT1 -> outputs take reset values before the next edge; a following mem_rvalid is ignored; the next request is accepted normally.
